// File: rtl/ins_cache_pkg.sv
// ins_cache_pkg: shared RAM address width, data width and fetch FSM state encodings
package ins_cache_pkg;
  localparam int RAM_ADR_W = 17;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, CHECK = 2'd2} state_e;
endpackage

// File: rtl/ins_cache_lookup.sv
// ic_lookup: combinational tag/valid check and 32-bit instruction assembly for one PC
// pc_i in; valid_i/tags_i/data_i are the cache arrays; hit_o, miss_adr_o (first missing line), ins_o out
module ic_lookup
  import ins_cache_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int LINES = 32,
  parameter int ADR_W = RAM_ADR_W
) (
  input  logic [ADR_W-1:0] pc_i,
  input  logic [LINES-1:0] valid_i,
  input  logic [LINES-1:0][ADR_W-$clog2(LINE_BYTES)-$clog2(LINES)-1:0] tags_i,
  input  logic [LINES-1:0][LINE_BYTES*8-1:0] data_i,
  output logic hit_o,
  output logic [ADR_W-1:0] miss_adr_o,
  output logic [DATA_W-1:0] ins_o
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADR_W - OFF_W - IDX_W;
  logic [ADR_W-1:0] a_adr, b_adr;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic [OFF_W-1:0] off;
  logic [LINE_BYTES*8-1:0] a_line;
  logic [15:0] lo, b_lo;
  logic [31:0] plain;
  logic a_hit, b_hit, straddle, need_b;
  always_comb begin
    a_adr = {pc_i[ADR_W-1:OFF_W], {OFF_W{1'b0}}};
    b_adr = a_adr + ADR_W'(LINE_BYTES);
    a_idx = a_adr[OFF_W +: IDX_W];
    b_idx = b_adr[OFF_W +: IDX_W];
    a_hit = valid_i[a_idx] && tags_i[a_idx] == a_adr[ADR_W-1 -: TAG_W];
    b_hit = valid_i[b_idx] && tags_i[b_idx] == b_adr[ADR_W-1 -: TAG_W];
    off = pc_i[OFF_W-1:0] & ~OFF_W'(1);
    a_line = data_i[a_idx];
    b_lo = data_i[b_idx][15:0];
    plain = 32'(a_line >> {off, 3'b000});
    lo = a_line[LINE_BYTES*8-1 -: 16];
    straddle = off == OFF_W'(LINE_BYTES - 2);
    // a compressed low half at the line end needs nothing from the next line
    need_b = straddle && lo[1:0] == 2'b11;
    hit_o = a_hit && (!need_b || b_hit);
    miss_adr_o = a_hit ? b_adr : a_adr;
    ins_o = straddle ? {need_b ? b_lo : 16'h0000, lo} : plain;
  end
endmodule

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped read-only instruction cache with line refill and flush cancel
// fetch side: if_en_i/if_pc_i request, if_en_o/if_ins_o response, br_i flush
// memory side: mc_en_o/mc_adr_o refill request, mc_done_i/mc_dat_i line return
// ICACHE_PERF_EN adds hit_cnt_o (IDLE hits) and miss_cnt_o (line refills)
module ins_cache
  import ins_cache_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int LINES = 32,
  parameter int ADR_W = RAM_ADR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic if_en_i,
  input  logic [ADR_W-1:0] if_pc_i,
  output logic if_en_o,
  output logic [DATA_W-1:0] if_ins_o,
  input  logic br_i,
  output logic mc_en_o,
  output logic [ADR_W-1:0] mc_adr_o,
  input  logic mc_done_i,
  input  logic [LINE_BYTES*8-1:0] mc_dat_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADR_W - OFF_W - IDX_W;
  state_e state_q, state_d;
  logic [ADR_W-1:0] req_pc_q, req_pc_d, pend_pc_q, pend_pc_d, mc_adr_q, mc_adr_d, lk_pc, lk_miss_adr;
  logic cancel_q, cancel_d, pend_q, pend_d, resp_en_q, resp_en_d, mc_en_q, mc_en_d;
  logic lk_hit, wr_en, idle_hit;
  logic [DATA_W-1:0] resp_ins_q, resp_ins_d, lk_ins;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0] tags_q;
  logic [LINES-1:0][LINE_BYTES*8-1:0] data_q;
  logic [IDX_W-1:0] wr_idx;
  assign lk_pc = state_q == IDLE ? if_pc_i : req_pc_q;
  ic_lookup #(.LINE_BYTES(LINE_BYTES), .LINES(LINES), .ADR_W(ADR_W)) u_lookup (
    .pc_i(lk_pc),
    .valid_i(valid_q),
    .tags_i(tags_q),
    .data_i(data_q),
    .hit_o(lk_hit),
    .miss_adr_o(lk_miss_adr),
    .ins_o(lk_ins)
  );
  always_comb begin
    state_d = state_q;
    req_pc_d = req_pc_q;
    cancel_d = cancel_q || br_i;
    pend_d = pend_q && !br_i;
    pend_pc_d = pend_pc_q;
    resp_en_d = 1'b0;
    resp_ins_d = resp_ins_q;
    mc_en_d = mc_en_q;
    mc_adr_d = mc_adr_q;
    valid_d = valid_q;
    wr_en = 1'b0;
    wr_idx = mc_adr_q[OFF_W +: IDX_W];
    idle_hit = 1'b0;
    // a post-flush request arriving mid-refill waits in the one-entry pending slot
    if (state_q != IDLE && if_en_i && !br_i && cancel_q) begin
      pend_d = 1'b1;
      pend_pc_d = if_pc_i;
    end
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (if_en_i && !br_i) begin
          idle_hit = lk_hit;
          resp_en_d = lk_hit;
          resp_ins_d = lk_hit ? lk_ins : resp_ins_q;
          state_d = lk_hit ? IDLE : FILL;
          req_pc_d = lk_hit ? req_pc_q : if_pc_i;
          mc_en_d = !lk_hit;
          mc_adr_d = lk_hit ? mc_adr_q : lk_miss_adr;
        end
      end
      FILL: begin
        if (mc_done_i) begin
          wr_en = 1'b1;
          valid_d[wr_idx] = 1'b1;
          mc_en_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cancel_d) begin
          state_d = pend_d ? CHECK : IDLE;
          req_pc_d = pend_d ? pend_pc_d : req_pc_q;
          pend_d = 1'b0;
          cancel_d = 1'b0;
        end else if (lk_hit) begin
          resp_en_d = 1'b1;
          resp_ins_d = lk_ins;
          state_d = IDLE;
        end else begin
          state_d = FILL;
          mc_en_d = 1'b1;
          mc_adr_d = lk_miss_adr;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_pc_q <= '0;
      pend_pc_q <= '0;
      cancel_q <= 1'b0;
      pend_q <= 1'b0;
      resp_en_q <= 1'b0;
      resp_ins_q <= '0;
      mc_en_q <= 1'b0;
      mc_adr_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      req_pc_q <= req_pc_d;
      pend_pc_q <= pend_pc_d;
      cancel_q <= cancel_d;
      pend_q <= pend_d;
      resp_en_q <= resp_en_d;
      resp_ins_q <= resp_ins_d;
      mc_en_q <= mc_en_d;
      mc_adr_q <= mc_adr_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= mc_dat_i;
      tags_q[wr_idx] <= mc_adr_q[ADR_W-1 -: TAG_W];
    end
  end
  assign if_en_o = resp_en_q;
  assign if_ins_o = resp_ins_q;
  assign mc_en_o = mc_en_q;
  assign mc_adr_o = mc_adr_q;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_q + 32'(idle_hit);
      miss_cnt_q <= miss_cnt_q + 32'(wr_en);
    end
  end
  assign hit_cnt_o = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: directed self-checking bench for ins_cache with a fixed-latency memory model
module tb_ins_cache;
  localparam int MEM_LAT = 3;
  logic clk, rst, if_en_i, br_i, mc_done_i;
  logic [16:0] if_pc_i;
  logic if_en_o, mc_en_o;
  logic [31:0] if_ins_o;
  logic [16:0] mc_adr_o;
  logic [127:0] mc_dat_i;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif
  int vectors = 0, miscompares = 0;
  int n_resp = 0, n_mc = 0, mc_cyc = 0, lat_cnt = 0;
  logic [31:0] last_ins = '0;
  logic [16:0] mc_log [0:63];
  logic ovr_en = 1'b0;
  logic [7:0] ovr_e = '0, ovr_f = '0;
  int r0, m0, c0;

  ins_cache dut (
    .clk(clk), .rst(rst), .if_en_i(if_en_i), .if_pc_i(if_pc_i),
    .if_en_o(if_en_o), .if_ins_o(if_ins_o), .br_i(br_i),
    .mc_en_o(mc_en_o), .mc_adr_o(mc_adr_o), .mc_done_i(mc_done_i), .mc_dat_i(mc_dat_i)
`ifdef ICACHE_PERF_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(input logic [16:0] a);
    logic [7:0] b;
    b = a[7:0] ^ a[15:8] ^ (a[16] ? 8'h02 : 8'h00);
    if (ovr_en && a == 17'h0000E) b = ovr_e;
    if (ovr_en && a == 17'h0000F) b = ovr_f;
    return b;
  endfunction

  function automatic logic [127:0] mline(input logic [16:0] adr);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = mbyte(17'(adr + 17'(i)));
    return l;
  endfunction

  initial begin
    mc_done_i = 1'b0;
    mc_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mc_done_i) mc_done_i = 1'b0;
      else if (!mc_en_o) lat_cnt = 0;
      else if (lat_cnt == MEM_LAT) begin
        mc_done_i = 1'b1;
        mc_dat_i = mline(mc_adr_o);
        mc_log[n_mc % 64] = mc_adr_o;
        n_mc++;
        lat_cnt = 0;
      end else lat_cnt++;
    end
  end

  always @(negedge clk) begin
    if (if_en_o) begin
      n_resp++;
      last_ins = if_ins_o;
    end
    if (mc_en_o) mc_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic req(input logic [16:0] pc);
    if_en_i = 1'b1;
    if_pc_i = pc;
    @(posedge clk);
    #1;
    if_en_i = 1'b0;
  endtask

  task automatic hit_chk(input string tag, input logic [16:0] pc, input logic [31:0] exp);
    c0 = mc_cyc;
    req(pc);
    chk({tag, "_en"}, 32'(if_en_o), 32'd1);
    chk({tag, "_ins"}, if_ins_o, exp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(if_en_o), 32'd0);
    chk({tag, "_nomc"}, 32'(mc_cyc - c0), 32'd0);
  endtask

  task automatic miss_chk(input string tag, input logic [16:0] pc, input logic [31:0] exp,
                          input int refills, input logic [16:0] adr0);
    r0 = n_resp;
    m0 = n_mc;
    req(pc);
    repeat (40) @(posedge clk);
    #1;
    chk({tag, "_nresp"}, 32'(n_resp - r0), 32'd1);
    chk({tag, "_ins"}, last_ins, exp);
    chk({tag, "_nmc"}, 32'(n_mc - m0), 32'(refills));
    chk({tag, "_adr"}, 32'(mc_log[m0 % 64]), 32'(adr0));
  endtask

  initial begin
    if_en_i = 1'b0;
    if_pc_i = '0;
    br_i = 1'b0;
    do_reset();
    chk("rst_if_en", 32'(if_en_o), 32'd0);
    chk("rst_ins", if_ins_o, 32'd0);
    chk("rst_mc_en", 32'(mc_en_o), 32'd0);
    chk("rst_mc_adr", 32'(mc_adr_o), 32'd0);

    // cold miss, then hit on the same PC
    req(17'h00000);
    chk("cold_mc_rise", 32'(mc_en_o), 32'd1);
    chk("cold_mc_adr", 32'(mc_adr_o), 32'h0);
    r0 = n_resp;
    repeat (40) @(posedge clk);
    #1;
    chk("cold_nresp", 32'(n_resp - r0), 32'd1);
    chk("cold_ins", last_ins, 32'h03020100);
    chk("cold_nmc", 32'(n_mc), 32'd1);
    hit_chk("cold_hit", 17'h00000, 32'h03020100);

    // straddle with a 32-bit instruction: needs line 0x10 as well
    do_reset();
    ovr_en = 1'b1;
    ovr_e = 8'h13;
    ovr_f = 8'h00;
    miss_chk("st32_l0", 17'h00000, 32'h03020100, 1, 17'h00000);
    miss_chk("st32", 17'h0000E, 32'h11100013, 1, 17'h00010);
    hit_chk("st32_hit", 17'h0000E, 32'h11100013);

    // straddle with a compressed low half: line 0x10 never fetched
    do_reset();
    ovr_e = 8'h01;
    ovr_f = 8'h45;
    miss_chk("st16", 17'h0000E, 32'h00004501, 1, 17'h00000);
    hit_chk("st16_hit", 17'h0000E, 32'h00004501);
    ovr_en = 1'b0;

    // flush mid-refill, then a post-flush request that is held pending
    do_reset();
    r0 = n_resp;
    m0 = n_mc;
    req(17'h00080);
    br_i = 1'b1;
    @(posedge clk);
    #1;
    br_i = 1'b0;
    @(posedge clk);
    #1;
    req(17'h00040);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_nresp", 32'(n_resp - r0), 32'd1);
    chk("flush_ins", last_ins, 32'h43424140);
    chk("flush_nmc", 32'(n_mc - m0), 32'd2);
    chk("flush_adr0", 32'(mc_log[m0 % 64]), 32'h00080);
    chk("flush_adr1", 32'(mc_log[(m0 + 1) % 64]), 32'h00040);
    hit_chk("flush_written", 17'h00080, 32'h83828180);

    // request and flush in the same cycle: dropped
    r0 = n_resp;
    c0 = mc_cyc;
    if_en_i = 1'b1;
    br_i = 1'b1;
    if_pc_i = 17'h00300;
    @(posedge clk);
    #1;
    if_en_i = 1'b0;
    br_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("same_nresp", 32'(n_resp - r0), 32'd0);
    chk("same_nomc", 32'(mc_cyc - c0), 32'd0);

    // address wrap on a straddle, then an index conflict evicting line 0
    do_reset();
    miss_chk("wrap", 17'h1FFFE, 32'h01000203, 2, 17'h1FFF0);
    chk("wrap_adr1", 32'(mc_log[(n_mc - 1) % 64]), 32'h00000);
    hit_chk("wrap_hit", 17'h1FFFE, 32'h01000203);
    miss_chk("conf", 17'h00200, 32'h01000302, 1, 17'h00200);
    miss_chk("conf_re", 17'h00000, 32'h03020100, 1, 17'h00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
